// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: state encodings, port IDs and default widths.
package data_mem_arbiter_pkg;
  localparam int ADDR_W_D  = 8;
  localparam int DATA_W_D  = 8;
  localparam int LEN_W_D   = 4;
  localparam int NUM_PORTS = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_FIR = 1'b1;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side burst handshake and the single-port data-memory bus.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              last;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (output req, we, addr, len, wdata, input gnt, last, rdata, rvalid);
  modport slave  (input req, we, addr, len, wdata, output gnt, last, rdata, rvalid);
endinterface

interface data_mem_bus_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              write;
  logic              read;

  modport master (output addr, wdata, write, read, input rdata);
  modport slave  (input addr, wdata, write, read, output rdata);
endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-input round-robin picker; the pointer only moves when both ports contend.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);
  always_comb begin
    gnt     = 2'b00;
    ptr_nxt = ptr;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        gnt     = ptr ? 2'b10 : 2'b01;
        ptr_nxt = ~ptr;
      end
      default: gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the CPU datapath (port 0) and the FIR engine (port 1)
// with round-robin arbitration and auto-incrementing bursts of len+1 beats.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int LEN_W  = LEN_W_D
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave p0,
  data_mem_arbiter_if.slave p1,
  data_mem_bus_if.master    mem
);
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } burst_t;

  logic [NUM_PORTS-1:0]             req;
  burst_t [NUM_PORTS-1:0]           breq;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata;

  assign req     = {p1.req, p0.req};
  assign breq[0] = {p0.we, p0.addr, p0.len};
  assign breq[1] = {p1.we, p1.addr, p1.len};
  assign wdata   = {p1.wdata, p0.wdata};

  logic [0:0]        state;
  logic              rr_ptr;
  logic              owner;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  cnt;

  logic [1:0] pick;
  logic       ptr_nxt;
  logic       win;

  rr_arb2 u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .gnt    (pick),
    .ptr_nxt(ptr_nxt)
  );

  assign win = pick[1] & ~pick[0];

  // Beats are masked by rst so an aborted burst never issues a write on the reset cycle's negedge.
  logic                 in_burst;
  logic [NUM_PORTS-1:0] beat;
  logic [NUM_PORTS-1:0] last_beat;

  assign in_burst  = (state == ST_BURST) && !rst;
  assign beat      = in_burst ? (2'b01 << owner) : 2'b00;
  assign last_beat = beat & {NUM_PORTS{cnt == '0}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= PORT_CPU;
      owner    <= PORT_CPU;
      cur_we   <= 1'b0;
      cur_addr <= '0;
      cnt      <= '0;
    end else if (state == ST_IDLE) begin
      if (|req) begin
        owner    <= win;
        cur_we   <= breq[win].we;
        cur_addr <= breq[win].addr;
        cnt      <= breq[win].len;
        rr_ptr   <= ptr_nxt;
        state    <= ST_BURST;
      end
    end else begin
      cur_addr <= cur_addr + 1'b1;
      cnt      <= cnt - 1'b1;
      if (cnt == '0) state <= ST_IDLE;
    end
  end

  logic [NUM_PORTS-1:0]             rvalid;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rvalid[i] <= beat[i] & ~cur_we;
        if (beat[i] && !cur_we) rdata[i] <= mem.rdata;
      end
    end
  end

  assign mem.addr  = cur_addr;
  assign mem.write = in_burst & cur_we;
  assign mem.read  = in_burst & ~cur_we;
  assign mem.wdata = in_burst ? wdata[owner] : '0;

  assign p0.gnt    = beat[0];
  assign p0.last   = last_beat[0];
  assign p0.rdata  = rdata[0];
  assign p0.rvalid = rvalid[0];
  assign p1.gnt    = beat[1];
  assign p1.last   = last_beat[1];
  assign p1.rdata  = rdata[1];
  assign p1.rvalid = rvalid[1];
endmodule
